// File: rtl/dpram_arb_pkg.sv
// Shared constants and response-tag type for the dual-port RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dpram_arb_pkg;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;

    // Tag id is sized for the largest legal requester count so one tag type
    // serves every parameterisation; smaller configs zero-extend their ids.
    localparam int MAX_N_REQ  = 8;
    localparam int ID_W       = $clog2(MAX_N_REQ);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } rsp_tag_t;

endpackage

// File: rtl/dpram_rr_pick.sv
// Circular find-first: lowest-distance set bit of i_mask scanning upward from i_start.
// Latency: purely combinational.
// Backpressure: none; o_found=0 when the mask is empty.
module dpram_rr_pick
    import dpram_arb_pkg::*;
#(
    parameter  int N  = DEF_N_REQ,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_mask,
    input  logic [IW-1:0] i_start,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    logic [IW-1:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest hit is written last
    // and wins; N is a power of two, so index wrap is plain truncation.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = i_start + IW'(k);
            if (i_mask[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter mapping up to two non-conflicting requests per cycle onto RAM ports A/B.
// Latency: grant is combinational (0 cycles); read data returns on rsp_valid one cycle after grant.
// Backpressure: req_ready low holds a request; responses are never stalled.
module dpram_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [N_REQ*DATA_W-1:0]   rsp_rdata,
    output logic [ADDR_W-1:0]         ram_addr_a,
    output logic [ADDR_W-1:0]         ram_addr_b,
    output logic [DATA_W-1:0]         ram_data_a,
    output logic [DATA_W-1:0]         ram_data_b,
    output logic                      ram_we_a,
    output logic                      ram_we_b,
    input  logic [DATA_W-1:0]         ram_q_a,
    input  logic [DATA_W-1:0]         ram_q_b
);

    localparam int            IW    = $clog2(N_REQ);
    localparam logic [IW-1:0] L_ONE = IW'(1);

    // Unpacked views of the per-requester buses for indexed muxing.
    logic [ADDR_W-1:0] w_addr  [N_REQ];
    logic [DATA_W-1:0] w_wdata [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_addr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign w_wdata[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    logic [IW-1:0]    r_rr_ptr;
    rsp_tag_t         r_tag_a;
    rsp_tag_t         r_tag_b;

    logic [N_REQ-1:0] w_mask0;
    logic [N_REQ-1:0] w_mask1;
    logic [N_REQ-1:0] w_conf;
    logic             w_g0;
    logic             w_g1;
    logic [IW-1:0]    w_p0_idx;
    logic [IW-1:0]    w_p1_idx;
    logic [IW-1:0]    w_p1_start;
    logic [N_REQ-1:0] w_ready;
    logic [N_REQ-1:0] w_rsp_vld;
    logic [N_REQ*DATA_W-1:0] w_rsp_dat;

    // Nothing is granted while reset is held, so the RAM sees no writes then.
    assign w_mask0 = rst ? '0 : req_valid;

    dpram_rr_pick #(.N(N_REQ)) u_pick0 (
        .i_mask  (w_mask0),
        .i_start (r_rr_ptr),
        .o_found (w_g0),
        .o_idx   (w_p0_idx)
    );

    // Requesters that may not share the cycle with pick 0: pick 0 itself, and
    // any same-address request where either side writes. Read/read is allowed.
    always_comb begin
        w_conf = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IW'(i) == w_p0_idx) begin
                w_conf[i] = 1'b1;
            end else if ((w_addr[i] == w_addr[w_p0_idx]) &&
                         (req_we[i] || req_we[w_p0_idx])) begin
                w_conf[i] = 1'b1;
            end
        end
    end

    // An empty mask0 forces an empty mask1, so pick 1 never fires without pick 0.
    assign w_mask1    = w_mask0 & ~w_conf;
    assign w_p1_start = w_p0_idx + L_ONE;

    dpram_rr_pick #(.N(N_REQ)) u_pick1 (
        .i_mask  (w_mask1),
        .i_start (w_p1_start),
        .o_found (w_g1),
        .o_idx   (w_p1_idx)
    );

    // Grant vector from the two picks.
    always_comb begin
        w_ready = '0;
        if (w_g0) w_ready[w_p0_idx] = 1'b1;
        if (w_g1) w_ready[w_p1_idx] = 1'b1;
    end

    assign req_ready = w_ready;

    // Pick 0 drives port A, pick 1 drives port B; an idle port is all zeros.
    assign ram_we_a   = w_g0 ? req_we[w_p0_idx]  : 1'b0;
    assign ram_addr_a = w_g0 ? w_addr[w_p0_idx]  : '0;
    assign ram_data_a = w_g0 ? w_wdata[w_p0_idx] : '0;
    assign ram_we_b   = w_g1 ? req_we[w_p1_idx]  : 1'b0;
    assign ram_addr_b = w_g1 ? w_addr[w_p1_idx]  : '0;
    assign ram_data_b = w_g1 ? w_wdata[w_p1_idx] : '0;

    // Advance the pointer past the last grant in scan order; tag granted reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_tag_a  <= '0;
            r_tag_b  <= '0;
        end else begin
            if (w_g1) begin
                r_rr_ptr <= w_p1_idx + L_ONE;
            end else if (w_g0) begin
                r_rr_ptr <= w_p0_idx + L_ONE;
            end
            r_tag_a.vld <= w_g0 && !req_we[w_p0_idx];
            r_tag_a.id  <= w_g0 ? ID_W'(w_p0_idx) : '0;
            r_tag_b.vld <= w_g1 && !req_we[w_p1_idx];
            r_tag_b.id  <= w_g1 ? ID_W'(w_p1_idx) : '0;
        end
    end

    // Steer each port's RAM output to the requester named in its tag. The two
    // tags never share an id, so the two assignments never collide.
    always_comb begin
        w_rsp_vld = '0;
        w_rsp_dat = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!rst && r_tag_a.vld && (r_tag_a.id == ID_W'(i))) begin
                w_rsp_vld[i]                 = 1'b1;
                w_rsp_dat[i*DATA_W +: DATA_W] = ram_q_a;
            end
            if (!rst && r_tag_b.vld && (r_tag_b.id == ID_W'(i))) begin
                w_rsp_vld[i]                 = 1'b1;
                w_rsp_dat[i*DATA_W +: DATA_W] = ram_q_b;
            end
        end
    end

    assign rsp_valid = w_rsp_vld;
    assign rsp_rdata = w_rsp_dat;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Bench for dpram_arbiter: directed table, fairness run and randomized traffic vs a reference model.
// Latency: checks each cycle at the falling edge.
// Backpressure: requests are held until granted.
module tb_dpram_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata, rsp_rdata;
    logic [AW-1:0]   ram_addr_a, ram_addr_b;
    logic [DW-1:0]   ram_data_a, ram_data_b, ram_q_a, ram_q_b;
    logic            ram_we_a, ram_we_b;

    always #5 clk = ~clk;

    dpram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
        .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
        .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
        .ram_q_a(ram_q_a), .ram_q_b(ram_q_b)
    );

    // Behavioural 1024x8 dual-port RAM with registered read data.
    logic [DW-1:0] ram_mem [1024];
    initial begin
        for (int i = 0; i < 1024; i++) ram_mem[i] = '0;
        ram_q_a = '0;
        ram_q_b = '0;
    end
    always @(posedge clk) begin
        if (ram_we_a) ram_mem[ram_addr_a] <= ram_data_a;
        if (ram_we_b) ram_mem[ram_addr_b] <= ram_data_b;
        ram_q_a <= ram_mem[ram_addr_a];
        ram_q_b <= ram_mem[ram_addr_b];
    end

    typedef struct packed {
        logic            rst;
        logic [N-1:0]    vld;
        logic [N-1:0]    we;
        logic [N*AW-1:0] addr;
        logic [N*DW-1:0] wdata;
        logic [N-1:0]    exp_rdy;
        logic [1:0]      exp_we;   // {we_a, we_b}
        logic [N-1:0]    exp_rsp;
        logic [N*DW-1:0] exp_dat;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: pointer, memory image, expected responses.
    int            m_rr;
    logic [DW-1:0] m_mem [1024];
    logic [N-1:0]  m_vld;
    logic [DW-1:0] m_dat [N];
    bit            mg0, mg1;
    int            mp0, mp1;
    int            rsp_cnt [N];

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] w,
                                input logic [9:0] a0, input logic [9:0] a1,
                                input logic [9:0] a2, input logic [9:0] a3,
                                input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [7:0] d3,
                                input logic [3:0] er, input logic [1:0] ew, input logic [3:0] es,
                                input logic [7:0] q0, input logic [7:0] q1,
                                input logic [7:0] q2, input logic [7:0] q3);
        vec_t t;
        t.rst = r; t.vld = v; t.we = w;
        t.addr = {a3, a2, a1, a0};
        t.wdata = {d3, d2, d1, d0};
        t.exp_rdy = er; t.exp_we = ew; t.exp_rsp = es;
        t.exp_dat = {q3, q2, q1, q0};
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] a_of(input int i);
        return req_addr[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] d_of(input int i);
        return req_wdata[i*DW +: DW];
    endfunction

    // Spec rules in plain form: first valid from the pointer, then the next
    // valid after it in circular order that is not a same-address write clash.
    task automatic model_picks();
        mg0 = 0; mg1 = 0; mp0 = 0; mp1 = 0;
        if (rst) return;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (req_valid[i]) begin mg0 = 1; mp0 = i; break; end
        end
        if (!mg0) return;
        for (int k = 1; k < N; k++) begin
            int i;
            i = (mp0 + k) % N;
            if (req_valid[i] && !(a_of(i) == a_of(mp0) && (req_we[i] || req_we[mp0]))) begin
                mg1 = 1; mp1 = i; break;
            end
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_rr = 0;
            m_vld = '0;
            return;
        end
        m_vld = '0;
        if (mg0 && !req_we[mp0]) begin m_vld[mp0] = 1'b1; m_dat[mp0] = m_mem[a_of(mp0)]; end
        if (mg1 && !req_we[mp1]) begin m_vld[mp1] = 1'b1; m_dat[mp1] = m_mem[a_of(mp1)]; end
        if (mg0 && req_we[mp0]) m_mem[a_of(mp0)] = d_of(mp0);
        if (mg1 && req_we[mp1]) m_mem[a_of(mp1)] = d_of(mp1);
        if (mg1) m_rr = (mp1 + 1) % N;
        else if (mg0) m_rr = (mp0 + 1) % N;
    endtask

    // One clock: drive at posedge+1, compare at negedge, advance model at posedge.
    task automatic step(input vec_t v, input bit use_tab);
        logic [N-1:0]  exp_rdy;
        logic [N-1:0]  exp_rv;
        logic [63:0]   exp_a, exp_b;
        rst = v.rst; req_valid = v.vld; req_we = v.we;
        req_addr = v.addr; req_wdata = v.wdata;
        @(negedge clk);
        model_picks();
        exp_rdy = '0;
        if (mg0) exp_rdy[mp0] = 1'b1;
        if (mg1) exp_rdy[mp1] = 1'b1;
        chk("ready", req_ready, exp_rdy);
        exp_a = mg0 ? {req_we[mp0], a_of(mp0), d_of(mp0)} : '0;
        exp_b = mg1 ? {req_we[mp1], a_of(mp1), d_of(mp1)} : '0;
        chk("port_a", {ram_we_a, ram_addr_a, ram_data_a}, exp_a);
        chk("port_b", {ram_we_b, ram_addr_b, ram_data_b}, exp_b);
        exp_rv = rst ? '0 : m_vld;
        chk("rsp_valid", rsp_valid, exp_rv);
        for (int i = 0; i < N; i++)
            if (exp_rv[i]) chk("rsp_rdata", rsp_rdata[i*DW +: DW], m_dat[i]);
        if (use_tab) begin
            chk("tab_ready", req_ready, v.exp_rdy);
            chk("tab_we", {ram_we_a, ram_we_b}, v.exp_we);
            chk("tab_rsp_valid", rsp_valid, v.exp_rsp);
            for (int i = 0; i < N; i++)
                if (v.exp_rsp[i]) chk("tab_rsp_rdata", rsp_rdata[i*DW +: DW], v.exp_dat[i*DW +: DW]);
        end
        for (int i = 0; i < N; i++) if (rsp_valid[i]) rsp_cnt[i]++;
        @(posedge clk);
        model_update();
        #1;
    endtask

    vec_t tab [16];
    vec_t cur;
    bit   granted [N];

    initial begin
        for (int i = 0; i < 1024; i++) m_mem[i] = '0;
        for (int i = 0; i < N; i++) begin m_dat[i] = '0; rsp_cnt[i] = 0; end
        m_rr = 0; m_vld = '0;
        rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;

        tab[0]  = mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0,  0, 0, 0, 0,  4'b0000, 2'b00, 4'b0000, 0, 0, 0, 0);
        tab[1]  = mk(0, 4'b0011, 4'b0011, 10, 20, 0, 0, 8'hAA, 8'h55, 0, 0, 4'b0011, 2'b11, 4'b0000, 0, 0, 0, 0);
        tab[2]  = mk(0, 4'b1100, 4'b0000, 0, 0, 10, 20, 0, 0, 0, 0, 4'b1100, 2'b00, 4'b0000, 0, 0, 0, 0);
        tab[3]  = mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0,  0, 0, 0, 0,  4'b0000, 2'b00, 4'b1100, 0, 0, 8'hAA, 8'h55);
        tab[4]  = mk(0, 4'b0011, 4'b0001, 5, 5, 0, 0,  8'h3C, 0, 0, 0, 4'b0001, 2'b10, 4'b0000, 0, 0, 0, 0);
        tab[5]  = mk(0, 4'b0010, 4'b0000, 0, 5, 0, 0,  0, 0, 0, 0,  4'b0010, 2'b00, 4'b0000, 0, 0, 0, 0);
        tab[6]  = mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0,  0, 0, 0, 0,  4'b0000, 2'b00, 4'b0010, 0, 8'h3C, 0, 0);
        tab[7]  = mk(0, 4'b0100, 4'b0100, 0, 0, 7, 0,  0, 0, 8'h77, 0, 4'b0100, 2'b10, 4'b0000, 0, 0, 0, 0);
        tab[8]  = mk(0, 4'b1010, 4'b0000, 0, 7, 0, 7,  0, 0, 0, 0,  4'b1010, 2'b00, 4'b0000, 0, 0, 0, 0);
        tab[9]  = mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0,  0, 0, 0, 0,  4'b0000, 2'b00, 4'b1010, 0, 8'h77, 0, 8'h77);
        tab[10] = mk(0, 4'b0001, 4'b0000, 10, 0, 0, 0, 0, 0, 0, 0,  4'b0001, 2'b00, 4'b0000, 0, 0, 0, 0);
        tab[11] = mk(1, 4'b0100, 4'b0100, 0, 0, 10, 0, 0, 0, 8'h11, 0, 4'b0000, 2'b00, 4'b0000, 0, 0, 0, 0);
        tab[12] = mk(0, 4'b1111, 4'b0000, 1, 2, 3, 4,  0, 0, 0, 0,  4'b0011, 2'b00, 4'b0000, 0, 0, 0, 0);
        tab[13] = mk(0, 4'b1100, 4'b0000, 0, 0, 3, 4,  0, 0, 0, 0,  4'b1100, 2'b00, 4'b0011, 0, 0, 0, 0);
        tab[14] = mk(0, 4'b0001, 4'b0000, 10, 0, 0, 0, 0, 0, 0, 0,  4'b0001, 2'b00, 4'b1100, 0, 0, 0, 0);
        tab[15] = mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0,  0, 0, 0, 0,  4'b0000, 2'b00, 4'b0001, 8'hAA, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;

        for (int t = 0; t < 16; t++) step(tab[t], 1'b1);

        // Fairness: all four read continuously at distinct addresses.
        for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
        cur = mk(0, 4'b1111, 4'b0000, 100, 101, 102, 103, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 100; c++) step(cur, 1'b0);
        for (int i = 0; i < N; i++) begin
            chk("fair_min", 64'(rsp_cnt[i] >= 49), 64'd1);
            chk("fair_max", 64'(rsp_cnt[i] <= 50), 64'd1);
        end

        // Randomized traffic with a small address window to force conflicts.
        cur = '0;
        for (int i = 0; i < N; i++) granted[i] = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            cur.rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < N; i++) begin
                if (!(cur.vld[i] && !granted[i])) begin
                    cur.vld[i] = ($urandom_range(0, 99) < 60);
                    cur.we[i]  = $urandom_range(0, 1);
                    cur.addr[i*AW +: AW]  = AW'($urandom_range(0, 7));
                    cur.wdata[i*DW +: DW] = DW'($urandom);
                end
            end
            step(cur, 1'b0);
            for (int i = 0; i < N; i++) granted[i] = (mg0 && mp0 == i) || (mg1 && mp1 == i);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
